// File: rtl/prbs_check_if.sv
// Receive word bus between the deserializer and the PRBS-31 checker.
// The checker always accepts, so only data and valid are carried.
interface prbs_check_if;
   logic [63:0] DIN;
   logic        VALID;

   modport master (output DIN, output VALID);
   modport slave  (input DIN, input VALID);
endinterface

// File: rtl/prbs_check.sv
// PRBS-31 receive checker: self-synchronising lock plus BER counters.
// One shared 64-bit state register holds the last word (HUNT) or the expected word (CHECK).
module prbs_check #(
   parameter int unsigned LOCK_WORDS = 4,
   parameter int unsigned BAD_BITS   = 8,
   parameter int unsigned LOSS_WORDS = 8
) (
   input  logic               CLKF,
   input  logic               RSTXF,
   prbs_check_if.slave        rx,
   input  logic               CLR,
   output logic               LOCK,
   output logic               ERR_WORD,
   output logic [31:0]        ERR_CNT,
   output logic [31:0]        WORD_CNT,
   output logic [7:0]         LOSS_CNT
);

   typedef enum logic {HUNT, CHECK} state_t;

   localparam logic [3:0] LOCK_L = 4'(LOCK_WORDS);
   localparam logic [3:0] LOSS_L = 4'(LOSS_WORDS);
   localparam logic [6:0] BAD_L  = 7'(BAD_BITS);

   state_t      state_q;
   logic        seeded_q;
   logic [63:0] st_q;
   logic [3:0]  clean_q;
   logic [3:0]  bad_q;
   logic        lock_q;
   logic        err_word_q;
   logic [31:0] err_cnt_q;
   logic [31:0] word_cnt_q;
   logic [7:0]  loss_cnt_q;

   logic [63:0] pred_d;
   logic [6:0]  ecnt_d;
   logic [32:0] err_sum_d;
   logic [31:0] err_cnt_d;
   logic [31:0] word_cnt_d;
   logic [7:0]  loss_cnt_d;
   logic [3:0]  clean_d;
   logic [3:0]  bad_d;
   logic        match_d;
   logic        bad_word_d;

   // Unroll s[n] = s[n-28] ^ s[n-31] 64 steps past the given word.
   function automatic logic [63:0] prbs_next(input logic [63:0] w);
      logic [127:0] s;
      logic [63:0]  r;
      s = '0;
      r = '0;
      for (int n = 0; n < 64; n++) s[n] = w[63-n];
      for (int n = 64; n < 128; n++) s[n] = s[n-28] ^ s[n-31];
      for (int j = 0; j < 64; j++) r[63-j] = s[64+j];
      return r;
   endfunction

   // Prediction, error popcount and saturating next counter values.
   always_comb begin
      pred_d     = prbs_next(st_q);
      ecnt_d     = 7'($countones(rx.DIN ^ pred_d));
      match_d    = (ecnt_d == 7'd0) && (rx.DIN != 64'd0);
      bad_word_d = (ecnt_d > BAD_L);
      err_sum_d  = {1'b0, err_cnt_q} + {26'd0, ecnt_d};
      err_cnt_d  = err_sum_d[32] ? 32'hFFFF_FFFF : err_sum_d[31:0];
      word_cnt_d = (&word_cnt_q) ? word_cnt_q : word_cnt_q + 32'd1;
      loss_cnt_d = (&loss_cnt_q) ? loss_cnt_q : loss_cnt_q + 8'd1;
      clean_d    = clean_q + 4'd1;
      bad_d      = bad_q + 4'd1;
   end

   // HUNT/CHECK state machine with registered status and counters.
   always_ff @(posedge CLKF or negedge RSTXF) begin
      if (!RSTXF) begin
         state_q    <= HUNT;
         seeded_q   <= 1'b0;
         st_q       <= '0;
         clean_q    <= '0;
         bad_q      <= '0;
         lock_q     <= 1'b0;
         err_word_q <= 1'b0;
         err_cnt_q  <= '0;
         word_cnt_q <= '0;
         loss_cnt_q <= '0;
      end else begin
         err_word_q <= 1'b0;
         if (rx.VALID) begin
            unique case (state_q)
               HUNT: begin
                  st_q     <= rx.DIN;
                  seeded_q <= 1'b1;
                  if (!seeded_q || !match_d) begin
                     clean_q <= '0;
                  end else if (clean_d == LOCK_L) begin
                     state_q <= CHECK;
                     lock_q  <= 1'b1;
                     clean_q <= '0;
                     bad_q   <= '0;
                  end else begin
                     clean_q <= clean_d;
                  end
               end
               CHECK: begin
                  st_q       <= pred_d;
                  err_word_q <= (ecnt_d != 7'd0);
                  err_cnt_q  <= err_cnt_d;
                  word_cnt_q <= word_cnt_d;
                  if (!bad_word_d) begin
                     bad_q <= '0;
                  end else if (bad_d == LOSS_L) begin
                     state_q    <= HUNT;
                     lock_q     <= 1'b0;
                     seeded_q   <= 1'b0;
                     clean_q    <= '0;
                     bad_q      <= '0;
                     loss_cnt_q <= loss_cnt_d;
                  end else begin
                     bad_q <= bad_d;
                  end
               end
            endcase
         end
         if (CLR) begin
            err_cnt_q  <= '0;
            word_cnt_q <= '0;
            loss_cnt_q <= '0;
         end
      end
   end

   assign LOCK     = lock_q;
   assign ERR_WORD = err_word_q;
   assign ERR_CNT  = err_cnt_q;
   assign WORD_CNT = word_cnt_q;
   assign LOSS_CNT = loss_cnt_q;

endmodule

// File: doc/prbs_check.md
# prbs_check

Receive-side checker for the 0090 BER link: consumes the 64-bit words recovered from the serial lane, one word per valid strobe, in the CLKF domain. It self-synchronises to the PRBS-31 pattern the transmit side loads into its 64-bit serializer, then counts checked words and bit errors for bit-error-rate measurement. It sits directly downstream of the receive deserializer and upstream of the status/readout logic.

## Interface
- LOCK_WORDS, 4: consecutive error-free words required in HUNT before lock (1..15).
- BAD_BITS, 8: a word with more than this many bit errors is "bad" (0..63).
- LOSS_WORDS, 8: consecutive bad words in CHECK that drop lock (1..15).

- CLKF  in  1  word clock; all logic on posedge.
- RSTXF  in  1  asynchronous, active-low reset.
- DIN  in  64  received word; DIN[63] is the earliest bit on the wire, DIN[0] the latest.
- VALID  in  1  DIN is a new word this cycle.
- CLR  in  1  synchronous clear of ERR_CNT, WORD_CNT, LOSS_CNT; does not affect lock state.
- LOCK  out  1  1 while in CHECK.
- ERR_WORD  out  1  one-cycle pulse: last checked word had at least one bit error.
- ERR_CNT  out  32  accumulated bit errors, saturating at 0xFFFF_FFFF.
- WORD_CNT  out  32  accumulated checked words, saturating at 0xFFFF_FFFF.
- LOSS_CNT  out  8  number of CHECK->HUNT transitions, saturating at 0xFF.

## Operation
- Sequence: s[n] = s[n-28] XOR s[n-31] (x^31+x^28+1), bits in wire order. Prediction of the next 64 bits from a 64-bit word is the recurrence unrolled 64 steps over that word's bits (only the latest 31 are needed).
- FSM states: HUNT (reset state), CHECK. Cycles with VALID=0 change nothing (gaps allowed anywhere).
- HUNT:
  - The first valid word after reset or after entry to HUNT only seeds the predictor; clean count = 0.
  - Each later valid word is compared with the prediction from the previous received word. Match and word != 0 -> clean count +1. Otherwise clean count = 0. The all-zero word never counts as clean (it prevents false lock on a dead lane).
  - When clean count reaches LOCK_WORDS -> CHECK. The expected-state register is loaded with that word.
  - No counter updates and no ERR_WORD in HUNT.
- CHECK:
  - The expected word is generated from the internal expected state, never from received data, so one line error is counted once.
  - Per valid word, e = popcount(DIN XOR expected):
    - WORD_CNT += 1 and ERR_CNT += e. Both saturate and never wrap.
    - ERR_WORD = (e != 0).
    - The expected state advances.
  - e > BAD_BITS -> bad count +1, else bad count = 0. Reaching LOSS_WORDS -> HUNT and LOSS_CNT += 1. The triggering word is still counted.
- CLR has priority over the increment in the same cycle: counters become 0 and that word's contribution is discarded.

## Timing
- Reset values: LOCK=0, ERR_WORD=0, ERR_CNT=0, WORD_CNT=0, LOSS_CNT=0, state HUNT, all internal counts 0.
- Every output is a register. Effects of a valid word sampled at edge k are visible after edge k, i.e. 1-cycle latency.
- LOCK rises in the cycle after the edge that samples the LOCK_WORDS-th clean word. From reset, with a clean stream and no gaps, that is the word at index LOCK_WORDS (0-based).
- LOCK falls in the cycle after the edge that samples the LOSS_WORDS-th consecutive bad word.
- ERR_WORD is high exactly one cycle per erroneous word, including back-to-back words.
- Popcount plus accumulation complete within one CLKF cycle; a pipeline register is not permitted.
- Reset mid-operation: immediate return to reset values. The next valid word is a seed word.

## Test plan
- Reset, then 10 clean PRBS-31 words (seed 0x7FFF_FFFF) with no gaps -> LOCK=1 after word index 4; WORD_CNT=5 after word 9; ERR_CNT=0; ERR_WORD never high.
- Locked; flip bit 17 of one word, then flip bits 0, 31 and 63 of a later word -> ERR_CNT 1 then 4; ERR_WORD pulses twice; LOCK stays 1.
- Locked; 8 consecutive words of random data (more than 8 errors each) -> LOCK drops after the 8th; LOSS_CNT=1. Resume clean PRBS at a different phase -> relock after 5 valid words.
- Reset, feed all-zero words continuously -> LOCK stays 0 indefinitely.
- Clean stream with VALID low on alternate cycles -> same lock point in word count as the no-gap case; counters unaffected by gaps.
- CLR asserted in the same cycle as an erroneous valid word -> ERR_CNT=0 and WORD_CNT=0 next cycle; next clean word gives WORD_CNT=1. Saturation, with counters forced near max via a long run -> hold at 0xFFFF_FFFF.
